multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore FSM that sequences a multi-cycle RV32 datapath: shared instruction/data memory, IR, old-PC register, ALU, ALUOut register, register file and the sign-extending immediate generator.
- Supports lw, sw, beq and R-type. Any other instruction sends the FSM to a sticky trap state.
- Emits every datapath strobe and mux select, including the immediate-format select. Handles a req/ready memory handshake with a timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req may wait for mem_ready; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; everything rises on posedge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted/completed the current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable, valid with mem_req
- addr_sel  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and old-PC register
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register-file write
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct
- imm_sel  out  2  immediate format: 00 = I, 01 = S, 10 = B
- result_sel  out  2  result bus: 00 = ALUOut, 01 = memory data register, 10 = ALU result
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky: unsupported opcode, or funct3 other than 000 on a branch
- bus_error  out  1  sticky: memory timeout
- state  out  4  current state, for debug
- instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset
  - While rst is high, all outputs are forced to 0 and the next state is FETCH.
  - The wait counter, illegal and bus_error clear.
  - Reset wins over every other event, including mid-instruction and in TRAP.
- Defaults: every strobe not listed for a state is 0; every select not listed is 00.
- State encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXEC_R = 6, ALU_WB = 7, BRANCH = 8, TRAP = 9.
- FETCH
  - Outputs: mem_req = 1, addr_sel = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_sel = 10.
  - ir_write and pc_write equal mem_ready.
  - Stay until mem_ready, then go to DECODE.
- DECODE
  - Outputs: alu_src_a = 01, alu_src_b = 01, imm_sel = 10, alu_op = 00. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011: MEM_ADDR.
    - 0110011: EXEC_R.
    - 1100011 with funct3 = 000: BRANCH.
    - Anything else: TRAP, setting illegal.
- MEM_ADDR
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - imm_sel = 00 for a load, 01 for a store.
  - Next state: MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_req = 1, addr_sel = 1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, result_sel = 01, retire = 1. Go to FETCH.
- MEM_WRITE: mem_req = 1, mem_we = 1, addr_sel = 1. On mem_ready, pulse retire and go to FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Go to ALU_WB.
- ALU_WB: reg_write = 1, result_sel = 00, retire = 1. Go to FETCH.
- BRANCH
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_sel = 00, pc_write = zero, retire = 1.
  - Go to FETCH.
- TRAP: all strobes 0. Stays in TRAP until rst.
- Latency with mem_ready asserted immediately: lw 5 cycles, sw 4, R-type 4, beq 3.
- Wait counter
  - Counts cycles in FETCH, MEM_READ and MEM_WRITE where mem_req = 1 and mem_ready = 0.
  - Clears on mem_ready and on any state change.
  - If it reaches MEM_TIMEOUT while mem_ready is still 0, the next state is TRAP and bus_error is set.
  - mem_ready arriving in the same cycle as the count reaching the limit wins: normal transition, no error.
- No pipelining: mem_req never asserts in two back-to-back states without an intervening ready.

Optional Feature:
- Macro: INSTRET_COUNTER_EN.
- Defined: instret is a 32-bit counter that clears on rst and increments on each retire, wrapping from 0xFFFFFFFF to 0.
- Undefined: instret is tied to 0 and no counter flops are inferred.

Test Plan:
- lw 0x0080A283, mem_ready always 1:
  - State sequence 0, 1, 2, 3, 4.
  - imm_sel = 00 in MEM_ADDR; reg_write and result_sel = 01 in cycle 5.
  - retire in cycle 5; instret goes from 0 to 1.
- sw 0x0050A623, mem_ready delayed 3 cycles in MEM_WRITE:
  - mem_req and mem_we stay high for 4 cycles.
  - imm_sel = 01 in MEM_ADDR.
  - retire on the ready cycle; reg_write never asserts.
- add 0x002081B3:
  - alu_op = 10 in EXEC_R; reg_write with result_sel = 00 in ALU_WB.
  - Back to FETCH after 4 cycles.
- beq 0x00208463:
  - With zero = 1: pc_write = 1 in BRANCH.
  - With zero = 0: pc_write = 0 in BRANCH.
  - Both cases take 3 cycles and imm_sel = 10 in DECODE.
- addi 0x00000013:
  - DECODE goes to TRAP; illegal = 1 and stays high over 20 cycles with no strobes.
  - rst resets to FETCH with illegal = 0.
- Timeout and reset:
  - With MEM_TIMEOUT = 16 and mem_ready held at 0 in FETCH: TRAP with bus_error = 1 after 16 wait cycles.
  - Repeat with mem_ready rising exactly at count 16: no error.
  - Separately, assert rst in MEM_READ: the next cycle is FETCH with all flags cleared.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between multicycle_controller and the RV32 datapath and memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  imm_sel;
    logic [1:0]  result_sel;
    logic        retire;
    logic        illegal;
    logic        bus_error;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, imm_sel, result_sel,
               retire, illegal, bus_error, state, instret
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, imm_sel, result_sel,
               retire, illegal, bus_error, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for a multi-cycle RV32 datapath (lw/sw/beq/R-type) with a memory timeout.
// Define INSTRET_COUNTER_EN to build the retired-instruction counter; otherwise instret reads 0.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        TRAP      = 4'd9
    } state_t;

    localparam logic [6:0]       OP_LOAD    = 7'b0000011;
    localparam logic [6:0]       OP_STORE   = 7'b0100011;
    localparam logic [6:0]       OP_RTYPE   = 7'b0110011;
    localparam logic [6:0]       OP_BRANCH  = 7'b1100011;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             illegal_q, bus_error_q;
    logic             set_illegal, set_bus_error;
    logic             mem_wait, timed_out;

    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, retire;
    logic [1:0] alu_src_a, alu_src_b, alu_op, imm_sel, result_sel;

    logic unused_funct7b5;
    assign unused_funct7b5 = bus.funct7b5;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_q | set_illegal;
            bus_error_q <= bus_error_q | set_bus_error;
        end
    end

    // A ready arriving on the limit cycle still completes normally.
    always_comb begin
        mem_wait  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
        timed_out = (MEM_TIMEOUT != 0) && mem_wait && !bus.mem_ready && (wait_q == WAIT_LIMIT);
    end

    always_comb begin
        state_d       = state_q;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        imm_sel       = 2'b00;
        result_sel    = 2'b00;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_sel = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_sel   = 2'b10;
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    state_d = MEM_ADDR;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = EXEC_R;
                end else if (bus.opcode == OP_BRANCH && bus.funct3 == 3'b000) begin
                    state_d = BRANCH;
                end else begin
                    state_d     = TRAP;
                    set_illegal = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_sel   = (bus.opcode == OP_STORE) ? 2'b01 : 2'b00;
                state_d   = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                result_sel = 2'b01;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = bus.zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        if (timed_out) begin
            state_d       = TRAP;
            set_bus_error = 1'b1;
        end
    end

    // Counter restarts whenever the request completes or the FSM moves on.
    always_comb begin
        wait_d = '0;
        if (mem_wait && !bus.mem_ready && (state_d == state_q)) wait_d = wait_q + CNT_W'(1);
    end

    assign bus.mem_req    = mem_req   & ~rst;
    assign bus.mem_we     = mem_we    & ~rst;
    assign bus.addr_sel   = addr_sel  & ~rst;
    assign bus.ir_write   = ir_write  & ~rst;
    assign bus.pc_write   = pc_write  & ~rst;
    assign bus.reg_write  = reg_write & ~rst;
    assign bus.retire     = retire    & ~rst;
    assign bus.alu_src_a  = rst ? '0 : alu_src_a;
    assign bus.alu_src_b  = rst ? '0 : alu_src_b;
    assign bus.alu_op     = rst ? '0 : alu_op;
    assign bus.imm_sel    = rst ? '0 : imm_sel;
    assign bus.result_sel = rst ? '0 : result_sel;
    assign bus.illegal    = illegal_q   & ~rst;
    assign bus.bus_error  = bus_error_q & ~rst;
    assign bus.state      = rst ? '0 : state_q;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign bus.instret = rst ? '0 : instret_q;
`else
    assign bus.instret = '0;
`endif
endmodule
